zxvga_sync_gen: RTL and testbench
=================================

ZXVGA_SYNC_GEN -- requirements
Module: zxvga_sync_gen

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 Parameters (name, default, meaning), one per line, SHALL be:
- H_ACTIVE, 720: visible pixels per line.
- H_SYNC, 64: hsync width in pixels.
- H_BACK, 32: horizontal back porch in pixels.
- V_ACTIVE, 576: visible lines.
- V_FRONT, 5: vertical front porch in lines.
- V_SYNC, 5: vsync width in lines.
- V_BACK, 39: vertical back porch in lines.
- SYNC_POL, 0: asserted sync level (0 = active-low).
REQ-003 Ports (name, direction, width, meaning), one per line, SHALL be:
- clk, in, 1: pixel-domain clock.
- reset_n, in, 1: asynchronous active-low reset.
- ce, in, 1: pixel enable; the block advances only when ce=1.
- machine_timing, in, 3: timing mode; passed through as the latched copy.
- ha_value, in, 11: horizontal front-porch length from the front-porch stage.
- hcount, out, 11: current pixel index within the line.
- vcount, out, 10: current line index within the frame.
- hsync, out, 1: horizontal sync.
- vsync, out, 1: vertical sync.
- active, out, 1: visible-region flag.
- line_start, out, 1: one-cycle pulse at hcount=0.
- frame_start, out, 1: one-cycle pulse at hcount=0, vcount=0.
- timing_latched, out, 3: machine_timing as captured for the current frame.

Function
REQ-004 The block SHALL hold a shadow register HFP (11 bit) and a shadow register timing_latched; both SHALL load from ha_value and machine_timing only on the ce cycle where the counters wrap to (0,0).
REQ-005 A captured ha_value of 0 SHALL be stored as 1, and any other value SHALL be stored unchanged.
REQ-006 Changes to ha_value or machine_timing mid-frame SHALL have no effect until the next frame wrap.
REQ-007 The line total SHALL be HT = H_ACTIVE + HFP + H_SYNC + H_BACK, computed in 12 bits; HT shall be constant within a frame.
REQ-008 On each ce=1 cycle, hcount SHALL increment; at hcount=HT-1, hcount SHALL wrap to 0 and vcount SHALL increment.
REQ-009 At vcount=VT-1 with a line wrap, vcount SHALL wrap to 0, where VT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK.
REQ-010 When ce=0, all counters and outputs SHALL hold, and line_start and frame_start SHALL be 0.
REQ-011 Horizontal phases (states ACTIVE, FRONT, SYNC, BACK) SHALL be:
- ACTIVE: hcount in [0, H_ACTIVE-1].
- FRONT: hcount in [H_ACTIVE, H_ACTIVE+HFP-1].
- SYNC: the next H_SYNC pixels.
- BACK: the remainder of the line.
Vertical phases SHALL be defined identically in lines.
REQ-012 hsync SHALL equal SYNC_POL during horizontal SYNC and ~SYNC_POL otherwise; vsync SHALL follow the same rule in vertical SYNC.
REQ-013 active SHALL be 1 only when both the horizontal and vertical phases are ACTIVE.
REQ-014 All outputs SHALL be registered and mutually aligned: hsync, vsync, active, line_start and frame_start SHALL describe the hcount/vcount values presented in the same cycle, with zero skew between them.
REQ-015 line_start SHALL be 1 for exactly the one ce cycle in which hcount=0 is presented; frame_start SHALL be 1 additionally only when vcount=0.
REQ-016 The counters SHALL never exceed HT-1 or VT-1.
REQ-017 There SHALL be no illegal or unreachable counter state: if the HFP load would make HT-1 smaller than the current hcount (impossible by construction, since loads occur only at 0), the design SHALL still wrap safely to 0.

Reset
REQ-018 While reset_n=0, the block SHALL drive:
- hcount=0, vcount=0;
- hsync=~SYNC_POL, vsync=~SYNC_POL;
- active=0, line_start=0, frame_start=0;
- HFP=48, timing_latched=0.
REQ-019 On the first ce cycle after reset release, the block SHALL capture ha_value and machine_timing, present hcount=0 and vcount=0, and pulse line_start and frame_start.
REQ-020 A reset asserted mid-frame SHALL return all outputs to their REQ-018 values asynchronously, without waiting for a clk edge.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- ha_value=48, ce=1 continuously: line period is 864 clocks; hsync low for hcount 768..831; frame is 864*625 clocks; vsync low for vcount 581..585.
- ha_value=64 (Pentagon, machine_timing=100): line period is 880 clocks; hsync low for hcount 784..847; timing_latched=100 after frame_start.
- ha_value switched from 48 to 64 at vcount=100: the current frame keeps 864-clock lines; 880-clock lines start exactly at the next frame_start.
- ce toggling 1,0,1,0: counts advance only on ce=1; the frame takes 2*864*625 clocks; line_start width is one ce cycle.
- reset_n pulsed low at hcount=500, vcount=300: all outputs reach reset values with no clk edge; after release, the first ce cycle presents hcount=0 with frame_start=1.
- ha_value=0: stored HFP=1; line period is 817 clocks.

Source files
------------

// File: rtl/zxvga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : zxvga_sync_gen
// Description : Pixel/line counter and sync generator for a ZX-style VGA
//               pipeline. The horizontal front porch (HFP) and the machine
//               timing mode are shadowed once per frame, at the (0,0) wrap, so
//               the line length is constant across a frame.
// Ports       : clk            - pixel-domain clock
//               reset_n        - asynchronous active-low reset
//               ce             - pixel enable, block advances only when 1
//               machine_timing - timing mode, latched at frame wrap
//               ha_value       - horizontal front-porch length, latched at wrap
//               hcount/vcount  - pixel / line index presented this cycle
//               hsync/vsync    - sync outputs, level SYNC_POL when asserted
//               active         - visible-region flag
//               line_start     - one ce-cycle pulse at hcount=0
//               frame_start    - one ce-cycle pulse at hcount=0, vcount=0
//               timing_latched - machine_timing captured for this frame
// Revision    : 1.0 - initial release
// ============================================================================
module zxvga_sync_gen #(
    parameter int H_ACTIVE = 720,
    parameter int H_SYNC   = 64,
    parameter int H_BACK   = 32,
    parameter int V_ACTIVE = 576,
    parameter int V_FRONT  = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BACK   = 39,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [2:0]  machine_timing,
    input  logic [10:0] ha_value,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic        line_start,
    output logic        frame_start,
    output logic [2:0]  timing_latched
);

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    localparam logic [11:0] C_H_ACT     = 12'(H_ACTIVE);
    localparam logic [11:0] C_H_SYNC    = 12'(H_SYNC);
    localparam logic [11:0] C_H_FIXED   = 12'(H_ACTIVE + H_SYNC + H_BACK);
    localparam logic [10:0] C_HFP_RESET = 11'd48;
    localparam logic [9:0]  C_V_FRONT   = 10'(V_ACTIVE);
    localparam logic [9:0]  C_V_SYNC    = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0]  C_V_BACK    = 10'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [9:0]  C_VT_M1     = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

    logic [10:0] r_hcount;
    logic [9:0]  r_vcount;
    logic [10:0] r_hfp;
    logic [2:0]  r_timing;
    logic        r_started;   // 0 until the first ce cycle after reset
    logic        r_hsync;
    logic        r_vsync;
    logic        r_active;
    logic        r_line_start;
    logic        r_frame_start;

    logic [11:0] w_ht;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_wrap;
    logic [10:0] w_h_next;
    logic [9:0]  w_v_next;
    logic [10:0] w_hfp_cap;
    logic [10:0] w_hfp_next;
    logic [11:0] w_hsync_start;
    logic [11:0] w_hsync_end;
    phase_t      w_hph;
    phase_t      w_vph;

    // Line length of the frame in progress; only changes at the (0,0) wrap.
    assign w_ht = C_H_FIXED + {1'b0, r_hfp};

    // ">=" rather than "==" so an out-of-range count still wraps to 0; the
    // all-ones test keeps an 11-bit counter from rolling over if HT > 2048.
    assign w_h_last = ({1'b0, r_hcount} >= (w_ht - 12'd1)) || (&r_hcount);
    assign w_v_last = (r_vcount >= C_VT_M1);

    // The first ce cycle after reset behaves like a frame wrap so that (0,0)
    // is presented together with line_start/frame_start and fresh shadows.
    assign w_wrap   = !r_started || (w_h_last && w_v_last);
    assign w_h_next = (!r_started || w_h_last) ? 11'd0 : r_hcount + 11'd1;
    assign w_v_next = w_wrap   ? 10'd0 :
                      w_h_last ? r_vcount + 10'd1 : r_vcount;

    assign w_hfp_cap  = (ha_value == 11'd0) ? 11'd1 : ha_value;
    assign w_hfp_next = w_wrap ? w_hfp_cap : r_hfp;

    // Phases are decoded for the position about to be presented, using the
    // HFP that will be in force for it, so all flags align with the counters.
    assign w_hsync_start = C_H_ACT + {1'b0, w_hfp_next};
    assign w_hsync_end   = w_hsync_start + C_H_SYNC;

    always_comb begin
        w_hph = PH_BACK;
        if ({1'b0, w_h_next} < C_H_ACT) begin
            w_hph = PH_ACTIVE;
        end else if ({1'b0, w_h_next} < w_hsync_start) begin
            w_hph = PH_FRONT;
        end else if ({1'b0, w_h_next} < w_hsync_end) begin
            w_hph = PH_SYNC;
        end
    end

    always_comb begin
        w_vph = PH_BACK;
        if (w_v_next < C_V_FRONT) begin
            w_vph = PH_ACTIVE;
        end else if (w_v_next < C_V_SYNC) begin
            w_vph = PH_FRONT;
        end else if (w_v_next < C_V_BACK) begin
            w_vph = PH_SYNC;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hcount      <= 11'd0;
            r_vcount      <= 10'd0;
            r_hfp         <= C_HFP_RESET;
            r_timing      <= 3'd0;
            r_started     <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_active      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (ce) begin
            r_hcount      <= w_h_next;
            r_vcount      <= w_v_next;
            r_hfp         <= w_hfp_next;
            r_started     <= 1'b1;
            r_hsync       <= (w_hph == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= (w_vph == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_active      <= (w_hph == PH_ACTIVE) && (w_vph == PH_ACTIVE);
            r_line_start  <= (w_h_next == 11'd0);
            r_frame_start <= w_wrap;
            if (w_wrap) begin
                r_timing <= machine_timing;
            end
        end else begin
            // Pulses last exactly one ce cycle; everything else holds.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign hcount         = r_hcount;
    assign vcount         = r_vcount;
    assign hsync          = r_hsync;
    assign vsync          = r_vsync;
    assign active         = r_active;
    assign line_start     = r_line_start;
    assign frame_start    = r_frame_start;
    assign timing_latched = r_timing;

endmodule
`default_nettype wire

// File: tb/tb_zxvga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_zxvga_sync_gen
// Description : Directed bench for zxvga_sync_gen. Horizontal timing uses the
//               default parameters; the vertical total is shortened to 6 lines
//               (2 active, 1 front, 2 sync, 1 back) so whole frames stay short.
//               One frame is therefore 864*6 = 5184 clocks at HFP=48.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zxvga_sync_gen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b0;
    logic [2:0]  machine_timing = 3'd0;
    logic [10:0] ha_value = 11'd48;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hsync;
    logic        vsync;
    logic        active;
    logic        line_start;
    logic        frame_start;
    logic [2:0]  timing_latched;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    zxvga_sync_gen #(
        .V_ACTIVE(2),
        .V_FRONT (1),
        .V_SYNC  (2),
        .V_BACK  (1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ce            (ce),
        .machine_timing(machine_timing),
        .ha_value      (ha_value),
        .hcount        (hcount),
        .vcount        (vcount),
        .hsync         (hsync),
        .vsync         (vsync),
        .active        (active),
        .line_start    (line_start),
        .frame_start   (frame_start),
        .timing_latched(timing_latched)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_hcount"}, int'(hcount), 0);
        chk({tag, "_vcount"}, int'(vcount), 0);
        chk({tag, "_hsync"},  int'(hsync), 1);
        chk({tag, "_vsync"},  int'(vsync), 1);
        chk({tag, "_active"}, int'(active), 0);
        chk({tag, "_lstart"}, int'(line_start), 0);
        chk({tag, "_fstart"}, int'(frame_start), 0);
        chk({tag, "_tlatch"}, int'(timing_latched), 0);
    endtask

    task automatic wait_frame_start(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!frame_start && n < 20000);
        chk(tag, int'(frame_start), 1);
    endtask

    task automatic wait_pos(input string tag, input int h, input int v);
        int n = 0;
        while (!(int'(hcount) == h && int'(vcount) == v) && n < 20000) begin
            tick();
            n++;
        end
        chk(tag, int'(hcount == 11'(h) && vcount == 10'(v)), 1);
    endtask

    // Starts on a line_start sample; returns the clocks to the next one.
    task automatic measure_line(output int period, output int hs_first,
                                output int hs_last, output int act);
        period = 0; hs_first = -1; hs_last = -1; act = 0;
        do begin
            if (hsync == 1'b0) begin
                if (hs_first < 0) hs_first = int'(hcount);
                hs_last = int'(hcount);
            end
            if (active) act++;
            tick();
            period++;
        end while (!line_start && period < 4000);
    endtask

    // Starts on a frame_start sample; returns the clocks to the next one.
    task automatic measure_frame(output int period, output int vs_first,
                                 output int vs_last, output int hmax,
                                 output int vmax, output int act);
        period = 0; vs_first = -1; vs_last = -1; hmax = 0; vmax = 0; act = 0;
        do begin
            if (vsync == 1'b0) begin
                if (vs_first < 0) vs_first = int'(vcount);
                vs_last = int'(vcount);
            end
            if (int'(hcount) > hmax) hmax = int'(hcount);
            if (int'(vcount) > vmax) vmax = int'(vcount);
            if (active) act++;
            tick();
            period++;
        end while (!frame_start && period < 30000);
    endtask

    initial begin
        int per, f0, f1, hm, vm, act, n, ls_cnt;
        logic [10:0] h_hold;

        // Reset state
        repeat (3) tick();
        chk_reset_values("reset");

        // First ce cycle after release presents (0,0) with both pulses
        ha_value       = 11'd48;
        machine_timing = 3'b011;
        reset_n        = 1'b1;
        ce             = 1'b1;
        tick();
        chk("first_hcount", int'(hcount), 0);
        chk("first_vcount", int'(vcount), 0);
        chk("first_lstart", int'(line_start), 1);
        chk("first_fstart", int'(frame_start), 1);
        chk("first_active", int'(active), 1);
        chk("first_tlatch", int'(timing_latched), 3);

        // HFP=48: 864-clock lines, hsync low 768..831, 720 visible pixels
        measure_line(per, f0, f1, act);
        chk("l48_period", per, 864);
        chk("l48_hs_first", f0, 768);
        chk("l48_hs_last", f1, 831);
        chk("l48_active", act, 720);
        chk("l48_next_fstart", int'(frame_start), 0);

        // Whole frame: 6 lines, vsync low on lines 3..4, bounded counters
        wait_frame_start("sync_frame48");
        measure_frame(per, f0, f1, hm, vm, act);
        chk("f48_period", per, 5184);
        chk("f48_vs_first", f0, 3);
        chk("f48_vs_last", f1, 4);
        chk("f48_hmax", hm, 863);
        chk("f48_vmax", vm, 5);
        chk("f48_active", act, 1440);

        // Switch to 64 mid-frame: current frame keeps 864 and old timing
        wait_pos("reach_v2", 0, 2);
        ha_value       = 11'd64;
        machine_timing = 3'b100;
        measure_line(per, f0, f1, act);
        chk("sw_old_period", per, 864);
        chk("sw_old_hs_first", f0, 768);
        chk("sw_old_tlatch", int'(timing_latched), 3);
        wait_frame_start("sync_frame64");
        chk("sw_new_tlatch", int'(timing_latched), 4);
        measure_line(per, f0, f1, act);
        chk("l64_period", per, 880);
        chk("l64_hs_first", f0, 784);
        chk("l64_hs_last", f1, 847);

        // ha_value=0 is stored as HFP=1 -> 817-clock lines
        ha_value = 11'd0;
        wait_frame_start("sync_frame0");
        measure_line(per, f0, f1, act);
        chk("l0_period", per, 817);
        chk("l0_hs_first", f0, 721);
        chk("l0_hs_last", f1, 784);

        // ce toggling 1,0,1,0: frame doubles, pulses last one ce cycle
        ha_value = 11'd48;
        wait_frame_start("sync_frame_ce");
        h_hold = hcount;
        ce = 1'b0;
        tick();
        chk("ce0_hold_hcount", int'(hcount), int'(h_hold));
        chk("ce0_lstart", int'(line_start), 0);
        chk("ce0_fstart", int'(frame_start), 0);
        ce = 1'b1;
        tick();
        chk("ce1_hcount", int'(hcount), 1);
        n = 2;
        ls_cnt = 0;
        do begin
            ce = ~ce;
            tick();
            n++;
            if (line_start) ls_cnt++;
        end while (!frame_start && n < 30000);
        chk("ce_frame_period", n, 10368);
        chk("ce_lstart_cycles", ls_cnt, 6);

        // Asynchronous reset at (500,1), with no clock edge involved
        ce = 1'b1;
        wait_pos("reach_500_1", 500, 1);
        chk("pre_reset_active", int'(active), 1);
        chk("pre_reset_tlatch", int'(timing_latched), 4);
        reset_n = 1'b0;
        #2;
        chk_reset_values("async_reset");
        machine_timing = 3'b101;
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        tick();
        chk("rel_hcount", int'(hcount), 0);
        chk("rel_vcount", int'(vcount), 0);
        chk("rel_fstart", int'(frame_start), 1);
        chk("rel_lstart", int'(line_start), 1);
        chk("rel_tlatch", int'(timing_latched), 5);
        measure_line(per, f0, f1, act);
        chk("rel_period", per, 864);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
